// File: rtl/vga_bram_scanout_if.sv
// BRAM read port between the scanout engine (master) and the framebuffer memory (slave).
interface vga_bram_scanout_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 12
);
  logic              bram_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_dout;

  modport master (output bram_en, output bram_addr, input bram_dout);
  modport slave  (input bram_en, input bram_addr, output bram_dout);
endinterface

// File: rtl/vga_bram_scanout.sv
// VGA timing generator that scans a downscaled RGB444 framebuffer out of BRAM.
// Macro VGA_SCANOUT_TEST_PATTERN_EN adds cfg_pattern and an 8-bar colour test pattern.
module vga_bram_scanout #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned PIX_DIV     = 4,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned DATA_W      = 12
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cfg_enable,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [11:0]       cfg_bg_color,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  input  logic              cfg_pattern,
`endif
  vga_bram_scanout_if.master bram,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              frame_start,
  output logic [9:0]        line_cnt
);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  typedef enum logic {StBlank, StVideo} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [31:0]       h_w, v_w;
  logic [ADDR_W-1:0] row_base_q, row_base_d, base_cur, pix_addr, addr_q;
  logic [DATA_W-1:0] pix_q;
  logic              tick, frame_tick, line_end, active, fetch, pat_cur, en_q;
  logic              hs1_q, vs1_q, act1_q, vid1_q;
  logic              hsync_q, vsync_q, fs_q;
  logic [11:0]       rgb_q, rgb_d;

  assign h_w        = 32'(h_q);
  assign v_w        = 32'(v_q);
  assign tick       = (32'(div_q) == PIX_DIV - 1);
  assign frame_tick = tick && (h_q == '0) && (v_q == '0);
  assign line_end   = tick && (h_w == H_TOTAL - 1);
  assign active     = (h_w < H_ACTIVE) && (v_w < V_ACTIVE);

  always_comb begin
    div_d = tick ? '0 : div_q + DW'(1);
    h_d   = h_q;
    v_d   = v_q;
    if (tick) h_d = line_end ? '0 : h_q + HW'(1);
    if (line_end) v_d = (v_w == V_TOTAL - 1) ? '0 : v_q + VW'(1);
  end

  // Mode is decided on the first tick of a frame and used for that tick already.
  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      case (state_q)
        StBlank: if (cfg_enable)  state_d = StVideo;
        StVideo: if (!cfg_enable) state_d = StBlank;
        default: state_d = StBlank;
      endcase
    end
  end

  // Row base steps once every 2^SCALE_SHIFT visible lines; sums wrap modulo 2^ADDR_W.
  always_comb begin
    row_base_d = row_base_q;
    if (frame_tick) begin
      row_base_d = cfg_base_addr;
    end else if (line_end && (v_w < V_ACTIVE) &&
                 (((v_w + 32'd1) & ((32'd1 << SCALE_SHIFT) - 32'd1)) == 32'd0)) begin
      row_base_d = row_base_q + ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
    end
  end

  assign base_cur       = frame_tick ? cfg_base_addr : row_base_q;
  assign pix_addr       = base_cur + ADDR_W'(h_q >> SCALE_SHIFT);
  assign fetch          = tick && active && (state_d == StVideo) && !pat_cur;
  assign bram.bram_en   = fetch;
  assign bram.bram_addr = fetch ? pix_addr : addr_q;

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
  localparam int unsigned BarW = H_ACTIVE / 8;
  localparam int unsigned BW   = (BarW > 1) ? $clog2(BarW) : 1;

  logic          pat_q, pat1_q;
  logic [BW-1:0] bar_px_q;
  logic [2:0]    bar_idx_q;
  logic [11:0]   patcol1_q;

  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 12'hFFF;
      3'd1:    bar_color = 12'hFF0;
      3'd2:    bar_color = 12'h0FF;
      3'd3:    bar_color = 12'h0F0;
      3'd4:    bar_color = 12'hF0F;
      3'd5:    bar_color = 12'hF00;
      3'd6:    bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase
  endfunction

  assign pat_cur = frame_tick ? cfg_pattern : pat_q;

  // Bar index tracks h_q without a divider.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pat_q     <= 1'b0;
      pat1_q    <= 1'b0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      patcol1_q <= '0;
    end else begin
      if (frame_tick) pat_q <= cfg_pattern;
      if (tick) begin
        pat1_q    <= pat_cur;
        patcol1_q <= bar_color(bar_idx_q);
        if (line_end) begin
          bar_px_q  <= '0;
          bar_idx_q <= '0;
        end else if (32'(bar_px_q) == BarW - 1) begin
          bar_px_q  <= '0;
          bar_idx_q <= bar_idx_q + 3'd1;
        end else begin
          bar_px_q  <= bar_px_q + BW'(1);
        end
      end
    end
  end
`else
  assign pat_cur = 1'b0;
`endif

  always_comb begin
    rgb_d = 12'h000;
    if (act1_q) begin
      rgb_d = vid1_q ? 12'(pix_q) : cfg_bg_color;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
      if (pat1_q) rgb_d = patcol1_q;
`endif
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= StBlank;
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      en_q       <= 1'b0;
      pix_q      <= '0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      act1_q     <= 1'b0;
      vid1_q     <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      rgb_q      <= '0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      row_base_q <= row_base_d;
      en_q       <= fetch;
      fs_q       <= frame_tick;
      if (fetch) addr_q <= pix_addr;
      if (en_q)  pix_q  <= bram.bram_dout;
      // Stage 1 holds this tick's flags; outputs take them one tick later with the fetched pixel.
      if (tick) begin
        hs1_q   <= !((h_w >= H_ACTIVE + H_FP) && (h_w < H_ACTIVE + H_FP + H_SYNC));
        vs1_q   <= !((v_w >= V_ACTIVE + V_FP) && (v_w < V_ACTIVE + V_FP + V_SYNC));
        act1_q  <= active;
        vid1_q  <= (state_d == StVideo);
        hsync_q <= hs1_q;
        vsync_q <= vs1_q;
        rgb_q   <= rgb_d;
      end
    end
  end

  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign frame_start = fs_q;
  assign line_cnt    = 10'(v_q);
endmodule

// File: tb/tb_vga_bram_scanout.sv
// Directed bench for vga_bram_scanout using a reduced timing set and a BRAM whose word n holds n[11:0].
module tb_vga_bram_scanout;
  localparam int unsigned HA = 32, HFP = 4, HSW = 8, HBP = 4;
  localparam int unsigned VA = 16, VFP = 2, VSW = 2, VBP = 2;
  localparam int unsigned PD = 2, SS = 2, AW = 15, DW = 12;
  localparam int unsigned HT = HA + HFP + HSW + HBP;  // 48
  localparam int unsigned VT = VA + VFP + VSW + VBP;  // 22
  localparam int unsigned FR = HT * VT;               // 1056 pixels per frame

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          cfg_enable = 1'b1;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [11:0]   cfg_bg_color = 12'h000;
  logic          cfg_pattern = 1'b0;
  logic          vga_hsync, vga_vsync, frame_start;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic [9:0]    line_cnt;

  int n_pass = 0;
  int n_total = 0;

  vga_bram_scanout_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vga_bram_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .PIX_DIV(PD), .SCALE_SHIFT(SS), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .cfg_enable    (cfg_enable),
    .cfg_base_addr (cfg_base_addr),
    .cfg_bg_color  (cfg_bg_color),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    .cfg_pattern   (cfg_pattern),
`endif
    .bram          (bus.master),
    .vga_hsync     (vga_hsync),
    .vga_vsync     (vga_vsync),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b),
    .frame_start   (frame_start),
    .line_cnt      (line_cnt)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) if (bus.bram_en) bus.bram_dout <= bus.bram_addr[11:0];

  int unsigned cyc = 0;
  int unsigned rel_cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;
  always @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) rel_cyc <= 0;
    else          rel_cyc <= rel_cyc + 1;

  function automatic int frame_of(input int unsigned rc);
    return int'(((rc + 1) / PD - 1) / FR);
  endfunction

  logic hs_prev = 1'b1, vs_prev = 1'b1;
  int hs_fall = -1, hs_period = -1, hs_low = -1;
  int vs_fall = -1, vs_period = -1, vs_low = -1;
  int fs_last = -1, fs_period = -1;
  int en_total = 0;
  int en_per_frame [16];

  always @(negedge ACLK) begin
    if (ARESETN === 1'b1) begin
      if (hs_prev && !vga_hsync) begin
        if (hs_fall >= 0) hs_period <= int'(cyc) - hs_fall;
        hs_fall <= int'(cyc);
      end
      if (!hs_prev && vga_hsync) hs_low <= int'(cyc) - hs_fall;
      if (vs_prev && !vga_vsync) begin
        if (vs_fall >= 0) vs_period <= int'(cyc) - vs_fall;
        vs_fall <= int'(cyc);
      end
      if (!vs_prev && vga_vsync) vs_low <= int'(cyc) - vs_fall;
      if (frame_start) begin
        if (fs_last >= 0) fs_period <= int'(cyc) - fs_last;
        fs_last <= int'(cyc);
      end
      if (bus.bram_en) begin
        en_total <= en_total + 1;
        if (frame_of(rel_cyc) < 16) en_per_frame[frame_of(rel_cyc)] <= en_per_frame[frame_of(rel_cyc)] + 1;
      end
    end
    hs_prev <= vga_hsync;
    vs_prev <= vga_vsync;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_rel(input int unsigned target);
    while (rel_cyc < target) @(negedge ACLK);
  endtask

  // Output for pixel k is visible after the tick edge of pixel k+1.
  task automatic goto_px(input int unsigned f, input int unsigned v, input int unsigned h);
    wait_rel(PD * (f * FR + v * HT + h + 2));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hsync"}, 32'(vga_hsync), 32'd1);
    check({tag, "_vsync"}, 32'(vga_vsync), 32'd1);
    check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'h0);
    check({tag, "_bram_en"}, 32'(bus.bram_en), 32'd0);
    check({tag, "_bram_addr"}, 32'(bus.bram_addr), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_line_cnt"}, 32'(line_cnt), 32'd0);
  endtask

  function automatic logic [31:0] rgb();
    return 32'({vga_r, vga_g, vga_b});
  endfunction

  int en_snap;

  initial begin
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    check_reset_vals("rst");
    ARESETN = 1'b1;

    wait_rel(2);
    check("fs_first", 32'(frame_start), 32'd1);
    wait_rel(3);
    check("fs_width", 32'(frame_start), 32'd0);

    // Frame 0: video, base 0
    goto_px(0, 3, 35);
    check("hs_before", 32'(vga_hsync), 32'd1);
    check("blank_rgb", rgb(), 32'h000);
    goto_px(0, 3, 36);
    check("hs_start", 32'(vga_hsync), 32'd0);
    goto_px(0, 9, 5);
    check("px_5_9", rgb(), 32'h011);
    check("line_cnt_9", 32'(line_cnt), 32'd9);
    goto_px(0, 15, 31);
    check("px_31_15", rgb(), 32'h01F);
    goto_px(0, 17, 0);
    check("vs_before", 32'(vga_vsync), 32'd1);
    goto_px(0, 18, 0);
    check("vs_start", 32'(vga_vsync), 32'd0);
    check("vs_rgb", rgb(), 32'h000);

    goto_px(2, 0, 0);
    check("hs_period", 32'(hs_period), 32'(PD * HT));
    check("hs_low", 32'(hs_low), 32'(PD * HSW));
    check("vs_period", 32'(vs_period), 32'(PD * FR));
    check("vs_low", 32'(vs_low), 32'(PD * HT * VSW));
    check("fs_period", 32'(fs_period), 32'(PD * FR));

    // Disable mid-frame 2: frame 2 keeps BRAM data, frame 3 shows background
    goto_px(2, 10, 0);
    cfg_enable   = 1'b0;
    cfg_bg_color = 12'hABC;
    goto_px(2, 12, 5);
    check("no_tear", rgb(), 32'h019);
    goto_px(3, 3, 40);
    check("bg_blanking", rgb(), 32'h000);
    goto_px(3, 9, 5);
    check("bg_active", rgb(), 32'hABC);

    goto_px(3, 12, 0);
    cfg_enable    = 1'b1;
    cfg_base_addr = 15'h7FF0;

    // Frame 4: base near the top of BRAM, wraps to 0
    goto_px(4, 0, 0);
    check("wrap_first", rgb(), 32'hFF0);
    check("en_frame0", 32'(en_per_frame[0]), 32'd512);
    check("en_frame2", 32'(en_per_frame[2]), 32'd512);
    check("en_frame3", 32'(en_per_frame[3]), 32'd0);
    goto_px(4, 2, 0);
    cfg_base_addr = 15'h0100;
    goto_px(4, 7, 31);
    check("wrap_top", rgb(), 32'hFFF);
    goto_px(4, 8, 0);
    check("wrap_zero", rgb(), 32'h000);
    goto_px(4, 8, 4);
    check("wrap_one", rgb(), 32'h001);
    goto_px(4, 15, 31);
    check("wrap_last", rgb(), 32'h00F);
    goto_px(4, 15, 40);
    check("addr_hold", 32'(bus.bram_addr), 32'h000F);
    check("en_idle", 32'(bus.bram_en), 32'd0);
    check("hs_low_frame4", 32'(vga_hsync), 32'd0);
    check("rgb_hblank", rgb(), 32'h000);

    // Frame 5 picks up the new base, then reset lands mid-line
    goto_px(5, 5, 20);
    check("new_base", rgb(), 32'h10D);
    #1 ARESETN = 1'b0;
    #1 check_reset_vals("async_rst");
    repeat (3) @(negedge ACLK);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    cfg_pattern = 1'b1;
`endif
    en_snap = en_total;
    ARESETN = 1'b1;

    goto_px(0, 0, 35);
    check("rel_hs_high", 32'(vga_hsync), 32'd1);
    goto_px(0, 0, 36);
    check("rel_hs_fall", 32'(vga_hsync), 32'd0);
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    goto_px(0, 2, 1);
    check("bar0", rgb(), 32'hFFF);
    goto_px(0, 2, 5);
    check("bar1", rgb(), 32'hFF0);
    goto_px(0, 2, 30);
    check("bar7", rgb(), 32'h000);
    goto_px(0, 20, 0);
    check("pattern_no_fetch", 32'(en_total - en_snap), 32'd0);
`else
    goto_px(0, 4, 6);
    check("rel_px", rgb(), 32'h109);
    goto_px(0, 20, 0);
    check("rel_fetch_cnt", 32'(en_total - en_snap), 32'd512);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
